sdram_iobus_bridge: RTL and testbench

SDRAM_IOBUS_BRIDGE -- requirements
Module: sdram_iobus_bridge

---
 rtl/sdram_iobus_bridge_pkg.sv | 26 ++
 rtl/sdram_iobus_bridge.sv | 176 +++++++++++++++++
 tb/tb_sdram_iobus_bridge.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_iobus_bridge_pkg.sv
// rtl/sdram_iobus_bridge_pkg.sv - shared definitions for the IO bus to SDRAM bridge
// Purpose: bridge state encoding, timeout read word, word-address slice bounds.
// Ports: none (package).
// Config: SDRAM_BRIDGE_RMW_EN adds the MERGE and WR_REQ states.
package sdram_iobus_bridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_REQ     = 3'd1,
      ST_RD_WAIT = 3'd2,
`ifdef SDRAM_BRIDGE_RMW_EN
      ST_MERGE   = 3'd3,
      ST_WR_REQ  = 3'd4,
`endif
      ST_DONE    = 3'd5
   } state_t;

   // Word returned to the IO bus when the controller never answers a read.
   localparam logic [31:0] TIMEOUT_WORD = 32'hDEADBEEF;

   // Byte address bits that form the SDRAM word address.
   localparam int WORD_ADDR_HI = 24;
   localparam int WORD_ADDR_LO = 2;
   localparam int WORD_ADDR_W  = WORD_ADDR_HI - WORD_ADDR_LO + 1;

endpackage

// File: rtl/sdram_iobus_bridge.sv
// rtl/sdram_iobus_bridge.sv - MCS IO bus to SDRAM controller request bridge
// Purpose: turns one IO bus transfer into SDRAM controller requests and a
//          single-cycle io_ready completion; reads time out to 32'hDEADBEEF.
// Ports: clk/rst (sync, active-high); io_* MCS IO bus slave side;
//        sd_* SDRAM controller request/response side; timeout_err sticky flag.
// Config: SDRAM_BRIDGE_RMW_EN enables read-modify-write for partial writes;
//         without it partial writes go out as full words.
module sdram_iobus_bridge
   import sdram_iobus_bridge_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   io_addr_strobe,
   input  logic                   io_read_strobe,
   input  logic                   io_write_strobe,
   input  logic [31:0]            io_address,
   input  logic [3:0]             io_byte_enable,
   input  logic [31:0]            io_write_data,
   output logic [31:0]            io_read_data,
   output logic                   io_ready,
   output logic [WORD_ADDR_W-1:0] sd_addr,
   output logic                   sd_rw,
   output logic [31:0]            sd_data_in,
   input  logic [31:0]            sd_data_out,
   input  logic                   sd_busy,
   output logic                   sd_in_valid,
   input  logic                   sd_out_valid,
   output logic                   timeout_err
);

   localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t                 state, state_nxt;
   logic [WORD_ADDR_W-1:0] addr_q;
   logic [31:0]            data_q;
   logic [31:0]            rd_q;
   logic                   wr_q;
   logic                   tmo_q;
   logic                   valid_prev_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   fire;
   logic                   direct_wr;
   logic                   unused_bits;

   // Address bits outside the word slice and the read strobe carry no
   // information: direction is taken from io_write_strobe alone.
   assign unused_bits = ^{io_address[31:WORD_ADDR_HI+1], io_address[WORD_ADDR_LO-1:0], io_read_strobe};

`ifdef SDRAM_BRIDGE_RMW_EN
   logic [3:0] be_q;
   logic       rmw_q;

   function automatic logic [31:0] merge_lanes(input logic [31:0] wr_word,
                                               input logic [31:0] rd_word,
                                               input logic [3:0]  be);
      logic [31:0] res;
      res = rd_word;
      for (int n = 0; n < 4; n++) begin
         if (be[n]) res[8*n +: 8] = wr_word[8*n +: 8];
      end
      return res;
   endfunction

   // A partial write first goes out as a read; only full writes go direct.
   assign direct_wr = wr_q & ~rmw_q;
`else
   assign direct_wr = wr_q;
`endif

   always_comb begin
      state_nxt = state;
      fire      = 1'b0;
      sd_rw     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (io_addr_strobe) begin
               state_nxt = (io_write_strobe && io_byte_enable == 4'b0000) ? ST_DONE : ST_REQ;
            end
         end
         ST_REQ: begin
            sd_rw = direct_wr;
            // valid_prev_q keeps request pulses from ever landing back to back
            if (!sd_busy && !valid_prev_q) begin
               fire      = 1'b1;
               state_nxt = direct_wr ? ST_DONE : ST_RD_WAIT;
            end
         end
         ST_RD_WAIT: begin
            if (sd_out_valid) begin
`ifdef SDRAM_BRIDGE_RMW_EN
               state_nxt = rmw_q ? ST_MERGE : ST_DONE;
`else
               state_nxt = ST_DONE;
`endif
            end else if (cnt_q == CNT_LAST) begin
               state_nxt = ST_DONE;
            end
         end
`ifdef SDRAM_BRIDGE_RMW_EN
         ST_MERGE: state_nxt = ST_WR_REQ;
         ST_WR_REQ: begin
            sd_rw = 1'b1;
            if (!sd_busy && !valid_prev_q) begin
               fire      = 1'b1;
               state_nxt = ST_DONE;
            end
         end
`endif
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         addr_q       <= '0;
         data_q       <= '0;
         rd_q         <= '0;
         wr_q         <= 1'b0;
         tmo_q        <= 1'b0;
         valid_prev_q <= 1'b0;
         cnt_q        <= '0;
         timeout_err  <= 1'b0;
`ifdef SDRAM_BRIDGE_RMW_EN
         be_q         <= '0;
         rmw_q        <= 1'b0;
`endif
      end else begin
         state        <= state_nxt;
         valid_prev_q <= fire;
         case (state)
            ST_IDLE: begin
               if (io_addr_strobe) begin
                  addr_q <= io_address[WORD_ADDR_HI:WORD_ADDR_LO];
                  data_q <= io_write_data;
                  wr_q   <= io_write_strobe;
                  tmo_q  <= 1'b0;
                  rd_q   <= '0;
`ifdef SDRAM_BRIDGE_RMW_EN
                  be_q   <= io_byte_enable;
                  rmw_q  <= io_write_strobe && (io_byte_enable != 4'b1111);
`endif
               end
            end
            ST_REQ: cnt_q <= '0;
            ST_RD_WAIT: begin
               if (sd_out_valid) begin
                  rd_q <= sd_data_out;
               end else if (cnt_q == CNT_LAST) begin
                  rd_q        <= TIMEOUT_WORD;
                  tmo_q       <= 1'b1;
                  timeout_err <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
`ifdef SDRAM_BRIDGE_RMW_EN
            ST_MERGE: data_q <= merge_lanes(data_q, rd_q, be_q);
`endif
            default: ;
         endcase
      end
   end

   assign sd_in_valid  = fire;
   assign sd_addr      = addr_q;
   assign sd_data_in   = data_q;
   assign io_ready     = (state == ST_DONE);
   // Writes report zero unless an aborted RMW read timed out.
   assign io_read_data = (state == ST_DONE && (!wr_q || tmo_q)) ? rd_q : 32'h0;

endmodule

// File: tb/tb_sdram_iobus_bridge.sv
// tb/tb_sdram_iobus_bridge.sv - self-checking bench for sdram_iobus_bridge
module tb_sdram_iobus_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        io_addr_strobe = 1'b0;
   logic        io_read_strobe = 1'b0;
   logic        io_write_strobe = 1'b0;
   logic [31:0] io_address = '0;
   logic [3:0]  io_byte_enable = '0;
   logic [31:0] io_write_data = '0;
   logic [31:0] io_read_data;
   logic        io_ready;
   logic [22:0] sd_addr;
   logic        sd_rw;
   logic [31:0] sd_data_in;
   logic [31:0] sd_data_out = '0;
   logic        sd_busy = 1'b0;
   logic        sd_in_valid;
   logic        sd_out_valid = 1'b0;
   logic        timeout_err;

   sdram_iobus_bridge dut (
      .clk(clk), .rst(rst),
      .io_addr_strobe(io_addr_strobe), .io_read_strobe(io_read_strobe),
      .io_write_strobe(io_write_strobe), .io_address(io_address),
      .io_byte_enable(io_byte_enable), .io_write_data(io_write_data),
      .io_read_data(io_read_data), .io_ready(io_ready),
      .sd_addr(sd_addr), .sd_rw(sd_rw), .sd_data_in(sd_data_in),
      .sd_data_out(sd_data_out), .sd_busy(sd_busy), .sd_in_valid(sd_in_valid),
      .sd_out_valid(sd_out_valid), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int pulse_cnt = 0;
   int ready_cnt = 0;
   int ready_cyc = 0;
   int resp_cnt = 0;
   int resp_lat = 3;
   bit resp_en = 1'b1;
   bit prev_valid = 1'b0;
   logic [22:0] resp_addr = '0;
   logic [22:0] last_addr = '0;
   logic [31:0] mem [logic [22:0]];
   logic [31:0] exp_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [22:0] a);
      return mem.exists(a) ? mem[a] : 32'h0;
   endfunction

   always @(posedge clk) cyc++;

   // SDRAM controller model and io_ready scoreboard, sampled at the falling edge.
   always @(negedge clk) begin
      sd_out_valid = 1'b0;
      if (resp_cnt > 0) begin
         resp_cnt--;
         if (resp_cnt == 0) begin
            sd_out_valid = 1'b1;
            sd_data_out  = mem_rd(resp_addr);
         end
      end
      if (sd_in_valid) begin
         check("no_back_to_back", {31'h0, prev_valid}, 32'h0);
         pulse_cnt++;
         last_addr = sd_addr;
         if (sd_rw) mem[sd_addr] = sd_data_in;
         else if (resp_en) begin
            resp_cnt  = resp_lat;
            resp_addr = sd_addr;
         end
      end
      prev_valid = sd_in_valid;
      if (io_ready) begin
         ready_cnt++;
         ready_cyc = cyc;
         check("ready_not_with_strobe", {31'h0, io_addr_strobe}, 32'h0);
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_io_ready: got data %h expected no completion", io_read_data);
         end else begin
            check("io_read_data", io_read_data, exp_q.pop_front());
         end
      end
   end

   task automatic start_xfer(input logic wr, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] data);
      @(posedge clk); #1;
      io_addr_strobe  = 1'b1;
      io_read_strobe  = ~wr;
      io_write_strobe = wr;
      io_address      = addr;
      io_byte_enable  = be;
      io_write_data   = data;
      @(posedge clk); #1;
      io_addr_strobe  = 1'b0;
      io_read_strobe  = 1'b0;
      io_write_strobe = 1'b0;
   endtask

   task automatic wait_ready(input int start, input int budget, input string name);
      int n = 0;
      while (ready_cnt == start && n < budget) begin
         @(posedge clk);
         n++;
      end
      if (ready_cnt == start) begin
         total++;
         bad++;
         $display("FAIL %s: io_ready count %0d, required a completion within %0d cycles", name, ready_cnt, budget);
      end
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      int          exp_pulses;
      logic [22:0] exp_sd_addr;
      logic [31:0] exp_mem;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int p0, r0, t0, lat, n;

      vecs[0] = '{1'b1, 32'h0000_0100, 4'b1111, 32'h1122_3344, 32'h0, 1, 23'h40, 32'h1122_3344};
      vecs[1] = '{1'b0, 32'h0000_0100, 4'b1111, 32'h0,         32'h1122_3344, 1, 23'h40, 32'h1122_3344};
`ifdef SDRAM_BRIDGE_RMW_EN
      vecs[2] = '{1'b1, 32'h0000_0100, 4'b0001, 32'h0000_00AA, 32'h0, 2, 23'h40, 32'h1122_33AA};
      vecs[3] = '{1'b0, 32'h0000_0100, 4'b1111, 32'h0,         32'h1122_33AA, 1, 23'h40, 32'h1122_33AA};
      vecs[5] = '{1'b1, 32'h0000_0204, 4'b1010, 32'hAABB_CCDD, 32'h0, 2, 23'h81, 32'hAA66_CC88};
      vecs[6] = '{1'b0, 32'h0000_0204, 4'b1111, 32'h0,         32'hAA66_CC88, 1, 23'h81, 32'hAA66_CC88};
`else
      vecs[2] = '{1'b1, 32'h0000_0100, 4'b0001, 32'h0000_00AA, 32'h0, 1, 23'h40, 32'h0000_00AA};
      vecs[3] = '{1'b0, 32'h0000_0100, 4'b1111, 32'h0,         32'h0000_00AA, 1, 23'h40, 32'h0000_00AA};
      vecs[5] = '{1'b1, 32'h0000_0204, 4'b1010, 32'hAABB_CCDD, 32'h0, 1, 23'h81, 32'hAABB_CCDD};
      vecs[6] = '{1'b0, 32'h0000_0204, 4'b1111, 32'h0,         32'hAABB_CCDD, 1, 23'h81, 32'hAABB_CCDD};
`endif
      vecs[4] = '{1'b1, 32'h0000_0204, 4'b0000, 32'hCAFE_F00D, 32'h0, 0, 23'h81, 32'h5566_7788};
      vecs[7] = '{1'b0, 32'hF1FF_FFFC, 4'b1111, 32'h0,         32'h0BAD_F00D, 1, 23'h7F_FFFF, 32'h0BAD_F00D};

      mem[23'h81]     = 32'h5566_7788;
      mem[23'h7F_FFFF] = 32'h0BAD_F00D;

      repeat (3) @(posedge clk);
      #1;
      check("rst_io_ready", {31'h0, io_ready}, 32'h0);
      check("rst_sd_in_valid", {31'h0, sd_in_valid}, 32'h0);
      check("rst_timeout_err", {31'h0, timeout_err}, 32'h0);
      check("rst_io_read_data", io_read_data, 32'h0);
      check("rst_sd_addr", {9'h0, sd_addr}, 32'h0);
      check("rst_sd_data_in", sd_data_in, 32'h0);
      check("rst_sd_rw", {31'h0, sd_rw}, 32'h0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         p0 = pulse_cnt;
         r0 = ready_cnt;
         exp_q.push_back(vecs[i].exp_rdata);
         start_xfer(vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wdata);
         wait_ready(r0, 200, $sformatf("vec%0d_ready", i));
         check($sformatf("vec%0d_pulses", i), pulse_cnt - p0, vecs[i].exp_pulses);
         if (vecs[i].exp_pulses > 0)
            check($sformatf("vec%0d_sd_addr", i), {9'h0, last_addr}, {9'h0, vecs[i].exp_sd_addr});
         check($sformatf("vec%0d_mem", i), mem_rd(vecs[i].exp_sd_addr), vecs[i].exp_mem);
      end

      // Controller busy for 20 cycles; a stray strobe mid-transfer is ignored.
      sd_busy = 1'b1;
      p0 = pulse_cnt;
      r0 = ready_cnt;
      exp_q.push_back(vecs[6].exp_rdata);
      start_xfer(1'b0, 32'h0000_0204, 4'b1111, 32'h0);
      repeat (5) @(posedge clk);
      start_xfer(1'b1, 32'h0000_0300, 4'b1111, 32'h1234_5678);
      repeat (13) @(posedge clk);
      #1;
      check("busy_no_pulse", pulse_cnt - p0, 0);
      sd_busy = 1'b0;
      wait_ready(r0, 100, "busy_ready");
      check("busy_one_pulse", pulse_cnt - p0, 1);
      check("stray_strobe_mem", mem_rd(23'hC0), 32'h0);
      check("stray_strobe_ready", ready_cnt - r0, 1);

      // Read that the controller never answers.
      resp_en = 1'b0;
      r0 = ready_cnt;
      exp_q.push_back(32'hDEAD_BEEF);
      start_xfer(1'b0, 32'h0000_0100, 4'b1111, 32'h0);
      t0 = cyc - 1;
      wait_ready(r0, 1200, "timeout_ready");
      lat = ready_cyc - t0;
      check("timeout_latency_in_range", {31'h0, (lat >= 1023 && lat <= 1028)}, 32'h1);
      check("timeout_err_set", {31'h0, timeout_err}, 32'h1);
      resp_en = 1'b1;

      // Reset while waiting for read data, then a late controller response.
      resp_lat = 10;
      p0 = pulse_cnt;
      r0 = ready_cnt;
      start_xfer(1'b0, 32'h0000_0100, 4'b1111, 32'h0);
      n = 0;
      while (pulse_cnt == p0 && n < 20) begin
         @(posedge clk);
         n++;
      end
      check("rst_test_read_issued", pulse_cnt - p0, 1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      check("rst_abandon_no_ready", ready_cnt - r0, 0);
      check("rst_clears_timeout_err", {31'h0, timeout_err}, 32'h0);
      resp_lat = 2;
      r0 = ready_cnt;
      exp_q.push_back(vecs[6].exp_rdata);
      start_xfer(1'b0, 32'h0000_0204, 4'b1111, 32'h0);
      wait_ready(r0, 100, "after_rst_ready");
      check("scoreboard_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
